scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_if.sv | 28 ++
 rtl/scan_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scan_sequencer_if.sv
// Coordinate stream between the scan sequencer and its consumer.
// The sequencer drives the valid/ready beat; the consumer drives ready.
interface scan_sequencer_if #(
   parameter int unsigned XBITS = 8,
   parameter int unsigned YBITS = 8
);
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [XBITS-1:0] out_x;
   logic [YBITS-1:0] out_y;

   modport master (
      output out_valid,
      output out_x,
      output out_y,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_x,
      input  out_y,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/scan_sequencer.sv
// Row-major rectangular scan generator: emits (x,y) beats over latched inclusive bounds.
// Optional macro SCAN_ABORT_EN adds an abort input that drops a running scan back to IDLE.
module scan_sequencer #(
   parameter int unsigned XBITS = 8,
   parameter int unsigned YBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [XBITS-1:0] x_min,
   input  logic [XBITS-1:0] x_max,
   input  logic [YBITS-1:0] y_min,
   input  logic [YBITS-1:0] y_max,
`ifdef SCAN_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic             err,
   scan_sequencer_if.master coord
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [XBITS-1:0] x_q;
   logic [YBITS-1:0] y_q;
   logic [XBITS-1:0] xmin_q;
   logic [XBITS-1:0] xmax_q;
   logic [YBITS-1:0] ymin_q;
   logic [YBITS-1:0] ymax_q;
   logic             err_q;

   logic             abort_c;
   logic             bounds_ok_c;
   logic             x_end_c;
   logic             y_end_c;
   logic             xfer_c;

`ifdef SCAN_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // Compare before increment so all-ones bounds terminate without wrapping
   assign bounds_ok_c = (x_min <= x_max) && (y_min <= y_max);
   assign x_end_c     = (x_q == xmax_q);
   assign y_end_c     = (y_q == ymax_q);
   assign xfer_c      = (state_q == S_SCAN) && coord.out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && bounds_ok_c) begin
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (abort_c) begin
               state_d = S_IDLE;
            end else if (xfer_c && x_end_c && y_end_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bound latch, coordinate walk and reject pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         x_q    <= '0;
         y_q    <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  xmin_q <= x_min;
                  xmax_q <= x_max;
                  ymin_q <= y_min;
                  ymax_q <= y_max;
                  x_q    <= x_min;
                  y_q    <= y_min;
                  err_q  <= !bounds_ok_c;
               end
            end
            S_SCAN: begin
               if (xfer_c) begin
                  if (!x_end_c) begin
                     x_q <= x_q + XBITS'(1);
                  end else if (!y_end_c) begin
                     x_q <= xmin_q;
                     y_q <= y_q + YBITS'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Moore outputs decoded from registered state
   always_comb begin
      coord.out_valid = 1'b0;
      coord.out_last  = 1'b0;
      coord.out_x     = x_q;
      coord.out_y     = y_q;
      busy            = 1'b0;
      done            = 1'b0;
      err             = err_q;
      case (state_q)
         S_SCAN: begin
            coord.out_valid = 1'b1;
            coord.out_last  = x_end_c && y_end_c;
            busy            = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
